// File: rtl/stimulus_gen.sv
// Parametrised pattern source: rotate-left, rotate-right or Galois LFSR
// bursts with parallel load, abort and per-step/burst-done flags.
module stimulus_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic             stop,
  output logic [WIDTH-1:0] number,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] number_q, number_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] step_f(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] n
  );
    logic [WIDTH-1:0] r;
    r = n;
    unique case (m)
      2'b00: r = {n[WIDTH-2:0], n[WIDTH-1]};
      2'b01: r = {n[0], n[WIDTH-1:1]};
      2'b10: begin
        // an all-zero register would lock the LFSR, so reseed
        if (n == '0) r = INIT;
        else r = (n >> 1) ^ (n[0] ? TAPS : '0);
      end
      default: r = n;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    rem_d    = rem_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (load) number_d = data;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = RUN;
            rem_d   = length;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (!load) begin
          number_d = step_f(mode, number_q);
          valid_d  = 1'b1;
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      number_q <= INIT;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign number = number_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_stimulus_gen.sv
// Directed bench for stimulus_gen: rotations, LFSR period, load/stop,
// reset and zero-length bursts.
module tb_stimulus_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [7:0]  data;
  logic [1:0]  mode;
  logic        start;
  logic [15:0] length;
  logic        stop;
  logic [7:0]  number;
  logic        valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  stimulus_gen dut (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .data   (data),
    .mode   (mode),
    .start  (start),
    .length (length),
    .stop   (stop),
    .number (number),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // flags packed as {valid,busy,done}
  task automatic chk_st(input string tag, input logic [7:0] n,
                        input logic [2:0] f);
    chk({tag, ".num"}, 16'(number), 16'(n));
    chk({tag, ".vbd"}, 16'({valid, busy, done}), 16'(f));
  endtask

  logic [255:0] seen;
  int           distinct;
  int           vcount;
  int           dcount;

  initial begin
    reset_n = 1'b0; load = 1'b0; data = 8'h00; mode = 2'b00;
    start = 1'b0; length = 16'd0; stop = 1'b0;
    tick(); tick();
    chk_st("reset", 8'h01, 3'b000);
    reset_n = 1'b1;

    // rotl burst of 4
    start = 1'b1; length = 16'd4; mode = 2'b00;
    tick();
    start = 1'b0;
    chk_st("rotl.start", 8'h01, 3'b010);
    tick(); chk_st("rotl.s1", 8'h02, 3'b110);
    tick(); chk_st("rotl.s2", 8'h04, 3'b110);
    tick(); chk_st("rotl.s3", 8'h08, 3'b110);
    tick(); chk_st("rotl.s4", 8'h10, 3'b100);
    tick(); chk_st("rotl.done", 8'h10, 3'b001);
    tick(); chk_st("rotl.idle", 8'h10, 3'b000);

    // load then rotr burst of 3
    load = 1'b1; data = 8'h81;
    tick();
    load = 1'b0;
    chk_st("load81", 8'h81, 3'b000);
    start = 1'b1; length = 16'd3; mode = 2'b01;
    tick();
    start = 1'b0;
    chk_st("rotr.start", 8'h81, 3'b010);
    tick(); chk_st("rotr.s1", 8'hC0, 3'b110);
    tick(); chk_st("rotr.s2", 8'h60, 3'b110);
    tick(); chk_st("rotr.s3", 8'h30, 3'b100);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("rotr.done_cnt", 16'(dcount), 16'd1);

    // full LFSR period
    load = 1'b1; data = 8'h01;
    tick();
    load = 1'b0;
    start = 1'b1; length = 16'd255; mode = 2'b10;
    tick();
    start = 1'b0;
    seen = '0; distinct = 0; vcount = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (valid) vcount++;
      if (number != 8'h00 && !seen[number]) distinct++;
      seen[number] = 1'b1;
      if (i == 0) chk("lfsr.s1", 16'(number), 16'hB8);
      if (i == 1) chk("lfsr.s2", 16'(number), 16'h5C);
      if (i == 2) chk("lfsr.s3", 16'(number), 16'h2E);
    end
    chk("lfsr.distinct", 16'(distinct), 16'd255);
    chk("lfsr.valid_cnt", 16'(vcount), 16'd255);
    chk_st("lfsr.end", 8'h01, 3'b100);
    tick(); chk_st("lfsr.done", 8'h01, 3'b001);

    // LFSR lockup reseed
    load = 1'b1; data = 8'h00;
    tick();
    load = 1'b0;
    chk_st("lock.load0", 8'h00, 3'b000);
    start = 1'b1; length = 16'd1;
    tick();
    start = 1'b0;
    tick(); chk_st("lock.reseed", 8'h01, 3'b100);
    tick(); chk_st("lock.done", 8'h01, 3'b001);

    // stop on the third valid cycle
    mode = 2'b00;
    start = 1'b1; length = 16'd10;
    tick();
    start = 1'b0;
    tick(); chk_st("stop.s1", 8'h02, 3'b110);
    tick(); chk_st("stop.s2", 8'h04, 3'b110);
    tick(); chk_st("stop.s3", 8'h08, 3'b110);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_st("stop.abort", 8'h08, 3'b000);
    dcount = 0; vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcount++;
      if (valid) vcount++;
    end
    chk("stop.no_done", 16'(dcount), 16'd0);
    chk("stop.no_valid", 16'(vcount), 16'd0);

    // load on the second RUN cycle
    load = 1'b1; data = 8'h01;
    tick();
    load = 1'b0;
    start = 1'b1; length = 16'd4; mode = 2'b00;
    tick();
    start = 1'b0;
    tick(); chk_st("ld.s1", 8'h02, 3'b110);
    load = 1'b1; data = 8'h55;
    tick();
    load = 1'b0;
    chk_st("ld.load", 8'h55, 3'b010);
    tick(); chk_st("ld.s2", 8'hAA, 3'b110);
    tick(); chk_st("ld.s3", 8'h55, 3'b110);
    tick(); chk_st("ld.s4", 8'hAA, 3'b100);
    tick(); chk_st("ld.done", 8'hAA, 3'b001);

    // hold mode still flags valid
    mode = 2'b11;
    start = 1'b1; length = 16'd2;
    tick();
    start = 1'b0;
    tick(); chk_st("hold.s1", 8'hAA, 3'b110);
    tick(); chk_st("hold.s2", 8'hAA, 3'b100);
    tick(); chk_st("hold.done", 8'hAA, 3'b001);

    // reset mid-burst
    mode = 2'b00;
    start = 1'b1; length = 16'd5;
    tick();
    start = 1'b0;
    tick(); chk_st("rst.s1", 8'h55, 3'b110);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_st("rst.mid", 8'h01, 3'b000);

    // zero-length burst
    start = 1'b1; length = 16'd0;
    tick();
    start = 1'b0;
    chk_st("zero.start", 8'h01, 3'b000);
    tick(); chk_st("zero.done", 8'h01, 3'b001);
    tick(); chk_st("zero.idle", 8'h01, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
